// File: rtl/ps_reg_bridge_pkg.sv
// Shared types and register bit positions for the PS-to-register-bus bridge.
package ps_reg_bridge_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SET   = 2'd2,
    OP_CLR   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_MOD  = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  localparam int CTRL_ADDR_LSB  = 0;
  localparam int CTRL_START_BIT = 16;
  localparam int CTRL_OP_LSB    = 17;
  localparam int CTRL_OP_MSB    = 18;

  localparam int STAT_DONE_BIT  = 0;
  localparam int STAT_ERR_BIT   = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_CNT_LSB   = 24;
  localparam int STAT_CNT_MSB   = 31;

endpackage

// File: rtl/ps_reg_bridge_start_sync.sv
// Synchroniser for the PS start bit with a rising-edge detector on its output.
module ps_reg_bridge_start_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic start_in,
  output logic start_lvl,
  output logic start_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], start_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign start_lvl  = sync_q[SYNC_STAGES-1];
  assign start_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ps_reg_bridge.sv
// Bridges PS control/data registers onto valid/ready register-bus read and write
// channels, with read-modify-write set/clear ops, per-phase timeout and status.
module ps_reg_bridge
  import ps_reg_bridge_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       o_ctrl,
  input  logic [31:0]       w_data,
  output logic [31:0]       i_ctrl,
  output logic [31:0]       r_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  output logic              bus_rvalid,
  input  logic              bus_rready,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  function automatic logic [DATA_W-1:0] modify(input op_e o, input logic [DATA_W-1:0] rd,
                                               input logic [DATA_W-1:0] opnd);
    return (o == OP_SET) ? (rd | opnd) : (rd & ~opnd);
  endfunction

  logic              start_lvl, start_edge, timed_out;
  state_e            state;
  op_e               op, op_in;
  logic [DATA_W-1:0] operand, r_data_q;
  logic              done, err, busy;
  logic [7:0]        count;
  logic [31:0]       phase_cnt;

  // Control bits outside the address/start/op fields and data bits above DATA_W are ignored.
  wire unused_ok = ^{o_ctrl, w_data};

  ps_reg_bridge_start_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .clk       (clk),
    .rstn      (rstn),
    .start_in  (o_ctrl[CTRL_START_BIT]),
    .start_lvl (start_lvl),
    .start_edge(start_edge)
  );

  assign op_in     = op_e'(o_ctrl[CTRL_OP_MSB:CTRL_OP_LSB]);
  assign timed_out = (TIMEOUT != 0) && (phase_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      op         <= OP_READ;
      operand    <= '0;
      r_data_q   <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wvalid <= 1'b0;
      bus_rvalid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      count      <= '0;
      phase_cnt  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!start_lvl) done <= 1'b0;
          if (start_edge) begin
            bus_addr  <= o_ctrl[CTRL_ADDR_LSB +: ADDR_W];
            op        <= op_in;
            operand   <= w_data[DATA_W-1:0];
            busy      <= 1'b1;
            err       <= 1'b0;
            phase_cnt <= '0;
            if (op_in == OP_WRITE) begin
              state      <= ST_WR;
              bus_wvalid <= 1'b1;
              bus_wdata  <= w_data[DATA_W-1:0];
            end else begin
              state      <= ST_RD;
              bus_rvalid <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (bus_rvalid && bus_rready) begin
            bus_rvalid <= 1'b0;
            r_data_q   <= bus_rdata;
            if (op == OP_READ) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              count <= count + 8'd1;
              state <= ST_IDLE;
            end else begin
              state <= ST_MOD;
            end
          end else if (timed_out) begin
            bus_rvalid <= 1'b0;
            err        <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            count      <= count + 8'd1;
            state      <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        ST_MOD: begin
          bus_wdata  <= modify(op, r_data_q, operand);
          bus_wvalid <= 1'b1;
          phase_cnt  <= '0;
          state      <= ST_WR;
        end
        ST_WR: begin
          if (bus_wvalid && bus_wready) begin
            bus_wvalid <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            count      <= count + 8'd1;
            state      <= ST_IDLE;
          end else if (timed_out) begin
            bus_wvalid <= 1'b0;
            err        <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            count      <= count + 8'd1;
            state      <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    i_ctrl                             = '0;
    i_ctrl[STAT_DONE_BIT]              = done;
    i_ctrl[STAT_ERR_BIT]               = err;
    i_ctrl[STAT_BUSY_BIT]              = busy;
    i_ctrl[STAT_CNT_MSB:STAT_CNT_LSB]  = count;
  end

  assign r_data = 32'(r_data_q);

endmodule

// File: tb/tb_ps_reg_bridge.sv
// Directed bench for ps_reg_bridge: read, write, set/clear, timeout, dropped starts, reset, count wrap.
module tb_ps_reg_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] o_ctrl = '0;
  logic [31:0] w_data = '0;
  logic [31:0] i_ctrl, r_data;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wvalid, bus_rvalid;
  logic        bus_wready = 1'b0;
  logic        bus_rready = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  logic [31:0] wr_last = '0;
  logic both_hi = 1'b0;

  always #5 clk = ~clk;

  ps_reg_bridge #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .o_ctrl(o_ctrl), .w_data(w_data), .i_ctrl(i_ctrl), .r_data(r_data),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
    .bus_rvalid(bus_rvalid), .bus_rready(bus_rready), .bus_rdata(bus_rdata)
  );

  always @(posedge clk) begin
    if (rstn && bus_wvalid && bus_wready) begin
      wr_count <= wr_count + 1;
      wr_last  <= bus_wdata;
    end
    if (bus_rvalid && bus_wvalid) both_hi <= 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wd);
    o_ctrl = {13'b0, op, 1'b1, 8'b0, addr};
    w_data = wd;
  endtask

  task automatic release_start();
    o_ctrl = '0;
    tick(4);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(3);
    checks++; if (i_ctrl !== 32'h0) begin failures++; $display("FAIL reset_ictrl got=%h exp=%h", i_ctrl, 32'h0); end
    checks++; if (r_data !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", r_data, 32'h0); end
    checks++; if ({bus_rvalid, bus_wvalid, bus_addr, bus_wdata} !== 42'h0) begin
      failures++; $display("FAIL reset_bus got=%b%b %h %h exp=0", bus_rvalid, bus_wvalid, bus_addr, bus_wdata); end
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic test_read();
    bus_rready = 1'b1; bus_rdata = 32'hCAFEF00D;
    issue(2'd0, 8'h12, 32'h0);
    tick(3);
    checks++; if (bus_rvalid !== 1'b1 || bus_addr !== 8'h12) begin
      failures++; $display("FAIL read_rvalid_rise got=%b addr=%h exp=1 addr=12", bus_rvalid, bus_addr); end
    tick(1);
    checks++; if (bus_rvalid !== 1'b0) begin failures++; $display("FAIL read_rvalid_width got=%b exp=0", bus_rvalid); end
    checks++; if (r_data !== 32'hCAFEF00D) begin failures++; $display("FAIL read_rdata got=%h exp=cafef00d", r_data); end
    checks++; if (i_ctrl !== 32'h0100_0001) begin failures++; $display("FAIL read_status got=%h exp=01000001", i_ctrl); end
    tick(2);
    checks++; if (i_ctrl[0] !== 1'b1) begin failures++; $display("FAIL read_done_hold got=%b exp=1", i_ctrl[0]); end
    release_start();
    checks++; if (i_ctrl !== 32'h0100_0000) begin failures++; $display("FAIL read_done_clear got=%h exp=01000000", i_ctrl); end
  endtask

  task automatic test_write_wait();
    bus_wready = 1'b0;
    issue(2'd1, 8'h34, 32'hA5A5A5A5);
    tick(3);
    checks++; if (bus_wvalid !== 1'b1 || bus_wdata !== 32'hA5A5A5A5 || bus_addr !== 8'h34) begin
      failures++; $display("FAIL write_rise got=%b %h %h exp=1 a5a5a5a5 34", bus_wvalid, bus_wdata, bus_addr); end
    checks++; if (i_ctrl[2] !== 1'b1) begin failures++; $display("FAIL write_busy got=%b exp=1", i_ctrl[2]); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++; if (bus_wvalid !== 1'b1 || bus_wdata !== 32'hA5A5A5A5 || bus_rvalid !== 1'b0) begin
        failures++; $display("FAIL write_hold%0d got=%b %h exp=1 a5a5a5a5", i, bus_wvalid, bus_wdata); end
    end
    bus_wready = 1'b1;
    tick(1);
    bus_wready = 1'b0;
    checks++; if (bus_wvalid !== 1'b0 || wr_count !== 1) begin
      failures++; $display("FAIL write_accept got=%b writes=%0d exp=0 writes=1", bus_wvalid, wr_count); end
    checks++; if (i_ctrl !== 32'h0200_0001) begin failures++; $display("FAIL write_status got=%h exp=02000001", i_ctrl); end
    release_start();
  endtask

  task automatic test_set_clr();
    logic [31:0] opnd [2];
    logic [31:0] exp_w [2];
    opnd[0] = 32'h0000000F; exp_w[0] = 32'h0000F0FF;
    opnd[1] = 32'h000000F0; exp_w[1] = 32'h0000F000;
    bus_rready = 1'b1; bus_wready = 1'b1; bus_rdata = 32'h0000F0F0;
    for (int k = 0; k < 2; k++) begin
      issue(k == 0 ? 2'd2 : 2'd3, 8'h05, opnd[k]);
      tick(3);
      checks++; if (bus_rvalid !== 1'b1 || bus_addr !== 8'h05) begin
        failures++; $display("FAIL rmw%0d_rd got=%b %h exp=1 05", k, bus_rvalid, bus_addr); end
      tick(1);
      checks++; if (bus_rvalid !== 1'b0 || bus_wvalid !== 1'b0 || r_data !== 32'h0000F0F0) begin
        failures++; $display("FAIL rmw%0d_mod got=%b%b %h exp=00 0000f0f0", k, bus_rvalid, bus_wvalid, r_data); end
      tick(1);
      checks++; if (bus_wvalid !== 1'b1 || bus_wdata !== exp_w[k]) begin
        failures++; $display("FAIL rmw%0d_wdata got=%b %h exp=1 %h", k, bus_wvalid, bus_wdata, exp_w[k]); end
      tick(1);
      checks++; if (i_ctrl !== {8'(3 + k), 24'h000001} || wr_last !== exp_w[k]) begin
        failures++; $display("FAIL rmw%0d_done got=%h %h exp=%h %h", k, i_ctrl, wr_last, {8'(3 + k), 24'h000001}, exp_w[k]); end
      release_start();
    end
  endtask

  task automatic test_timeout();
    int hi;
    int writes0;
    writes0 = wr_count;
    bus_rready = 1'b0; bus_wready = 1'b1; bus_rdata = 32'hDEADBEEF;
    issue(2'd2, 8'h07, 32'h1);
    tick(3);
    hi = (bus_rvalid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40 && hi > 0; i++) begin
      tick(1);
      if (bus_rvalid === 1'b1) hi++; else break;
    end
    checks++; if (hi !== 16 || bus_rvalid !== 1'b0) begin
      failures++; $display("FAIL timeout_width got=%0d exp=16", hi); end
    checks++; if (i_ctrl !== 32'h0500_0003) begin failures++; $display("FAIL timeout_status got=%h exp=05000003", i_ctrl); end
    checks++; if (r_data !== 32'h0000F0F0) begin failures++; $display("FAIL timeout_rdata got=%h exp=0000f0f0", r_data); end
    tick(3);
    checks++; if (wr_count !== writes0 || bus_wvalid !== 1'b0) begin
      failures++; $display("FAIL timeout_nowrite got=%0d exp=%0d", wr_count, writes0); end
    release_start();
    bus_rready = 1'b1; bus_rdata = 32'h11223344;
    issue(2'd0, 8'h20, 32'h0);
    tick(4);
    checks++; if (i_ctrl !== 32'h0600_0001 || r_data !== 32'h11223344) begin
      failures++; $display("FAIL timeout_recover got=%h %h exp=06000001 11223344", i_ctrl, r_data); end
    release_start();
  endtask

  task automatic test_back_to_back();
    int writes0;
    writes0 = wr_count;
    bus_wready = 1'b0;
    issue(2'd1, 8'h40, 32'h00000055);
    tick(3);
    o_ctrl[16] = 1'b0;
    tick(3);
    o_ctrl[16] = 1'b1;
    tick(4);
    checks++; if (bus_wvalid !== 1'b1 || bus_rvalid !== 1'b0) begin
      failures++; $display("FAIL b2b_wait got=%b%b exp=10", bus_wvalid, bus_rvalid); end
    bus_wready = 1'b1;
    tick(1);
    bus_wready = 1'b0;
    tick(8);
    checks++; if (wr_count !== writes0 + 1 || bus_wvalid !== 1'b0 || bus_rvalid !== 1'b0) begin
      failures++; $display("FAIL b2b_single got=%0d exp=%0d", wr_count, writes0 + 1); end
    checks++; if (i_ctrl !== 32'h0700_0001) begin failures++; $display("FAIL b2b_count got=%h exp=07000001", i_ctrl); end
    release_start();
  endtask

  task automatic test_reset_mid_and_wrap();
    bus_rready = 1'b0;
    issue(2'd0, 8'h09, 32'h0);
    tick(3);
    checks++; if (bus_rvalid !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", bus_rvalid); end
    rstn = 1'b0; o_ctrl = '0;
    tick(1);
    checks++; if (bus_rvalid !== 1'b0 || i_ctrl !== 32'h0 || r_data !== 32'h0) begin
      failures++; $display("FAIL rst_mid got=%b %h %h exp=0 0 0", bus_rvalid, i_ctrl, r_data); end
    tick(1);
    rstn = 1'b1;
    tick(4);
    checks++; if (bus_rvalid !== 1'b0 || i_ctrl !== 32'h0) begin
      failures++; $display("FAIL rst_no_resume got=%b %h exp=0 0", bus_rvalid, i_ctrl); end
    bus_wready = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      issue(2'd1, 8'(n), 32'(n));
      tick(4);
      checks++; if (i_ctrl !== {8'(n), 24'h000001}) begin
        failures++; $display("FAIL wrap_%0d got=%h exp=%h", n, i_ctrl, {8'(n), 24'h000001}); end
      release_start();
    end
    checks++; if (i_ctrl[31:24] !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%h exp=00", i_ctrl[31:24]); end
    checks++; if (both_hi !== 1'b0) begin failures++; $display("FAIL exclusive_valid got=%b exp=0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_set_clr();
    test_timeout();
    test_back_to_back();
    test_reset_mid_and_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
